conv1_feed_sched: RTL and testbench
===================================

// Module: conv1_feed_sched
// PURPOSE
// Sequencer feeding the conv1 parallel-multiply stage of the conv1/layer1 dense datapath.
// Bypass mode: reads 400-bit feature words from the global input-feature BRAM, emits the 25 x 16-bit lanes serially.
// Matrix mode: still issues the BRAM reads, forwards one matrix mult-add result per word.
// Owns word addressing, lane index, halt stalling and done signalling.
// PARAMETERS
// LANES      25    16-bit lanes per feature word (lane k = bram_data[16k+15:16k])
// DW         16    lane / result width
// ADDR_W     10    BRAM address width
// NUM_WORDS  1024  words per layer pass (1..2**ADDR_W)
// RD_LAT     2     BRAM read latency in cycles (>=1)
// PORTS
// clk        in   1            clock, all state on rising edge
// rst        in   1            asynchronous, active-high reset
// start      in   1            one-cycle pulse; begins a pass; ignored unless IDLE
// halt       in   1            global stall; freezes all state
// mode       in   1            0=bypass (serialize lanes), 1=matrix (forward mx_res); sampled on accepted start
// bram_rd    out  1            read strobe to feature BRAM
// bram_addr  out  ADDR_W       read address
// bram_data  in   LANES*DW     read data, valid RD_LAT cycles after bram_rd
// mx_res     in   DW           matrix mult-add result
// mx_res_v   in   1            mx_res valid pulse (arrives regardless of halt)
// fea_out    out  DW           feature sample to conv1 mult / weight fetch
// fea_v      out  1            fea_out valid, one cycle per sample
// lane_idx   out  5            current lane 0..LANES-1 (bypass), 0 in matrix mode
// busy       out  1            high from accepted start until DONE
// done       out  1            one-cycle pulse after last sample of the pass
// BEHAVIOUR
// Reset: all outputs 0, FSM=IDLE, word counter=0, lane counter=0, skid buffer empty, mode reg=0.
// FSM states and transitions:
// - IDLE: on start & !halt -> FETCH; latch mode; addr=0; busy<=1.
// - FETCH: bram_rd=1 for exactly one cycle at bram_addr=word counter -> WAIT.
// - WAIT: count RD_LAT cycles; then capture bram_data into word reg.
//   Then -> SERIAL if mode=0, -> MXWAIT if mode=1.
// - SERIAL: each cycle drive fea_out=word_reg lane[lane_idx], fea_v=1, lane_idx++.
//   At lane LANES-1: lane_idx<=0; if word==NUM_WORDS-1 -> DONE, else word++ and -> FETCH.
// - MXWAIT: when skid buffer valid, drive fea_out=skid data, fea_v=1, clear skid.
//   Then same last-word test as SERIAL (-> DONE or word++ -> FETCH).
// - DONE: done=1, busy<=0, word<=0 -> IDLE.
// Bypass throughput: 1 FETCH + RD_LAT + 25 cycles per word; first fea_v is RD_LAT+2 cycles after start.
// Halt:
// - While halt=1, FSM, counters, word reg, bram_addr and lane_idx hold.
// - bram_rd=0, fea_v=0, done=0 (a pending done pulse is deferred, not lost).
// - An outstanding BRAM read completing during halt is captured into a 1-entry read-return reg.
//   WAIT consumes it after release; the read is never reissued.
// Skid buffer (matrix mode):
// - mx_res_v captures mx_res into a 1-entry buffer even during halt.
// - mx_res_v while the buffer is full is an overflow: data dropped, sticky internal err flag set.
//   err is cleared only by rst.
// - mx_res_v in IDLE/DONE is ignored.
// Simultaneous start & halt: start ignored. start while busy: ignored.
// Address wrap: word counter never exceeds NUM_WORDS-1; no wrap past it within a pass.
// mode changes mid-pass have no effect.
// Reset asserted mid-pass aborts immediately to reset values; no done pulse.
// TESTING
// 1. Bypass, NUM_WORDS=2, bram word lanes = k+1 -> fea_out 1..25, 1..25.
//    50 fea_v pulses, lane_idx 0..24 twice, done 1 cycle after last, busy low after.
// 2. Bypass, halt held 5 cycles mid-SERIAL at lane 7 -> fea_v low 5 cycles.
//    Resumes at lane 7, no sample lost or repeated.
// 3. Halt asserted the cycle after bram_rd (RD_LAT=2) -> no second bram_rd.
//    Captured data emitted correctly after release.
// 4. Matrix mode, NUM_WORDS=3, mx_res=0x1111,0x2222,0x3333 -> exactly 3 fea_v with those values.
//    bram_addr 0,1,2; done after third.
// 5. Matrix mode, mx_res_v during halt, then second mx_res_v still halted -> first value kept, err set.
//    One fea_v after release.
// 6. start during busy and start&halt in IDLE -> ignored. rst mid-pass -> all outputs 0, IDLE, no done.

Source files
------------

// File: rtl/conv1_feed_sched.sv
// conv1_feed_sched
// Sequencer that feeds the conv1 parallel-multiply stage. In bypass mode it
// fetches one wide feature word from the input-feature BRAM and streams its
// 16-bit lanes out one per cycle. In matrix mode it still walks the BRAM
// addresses but forwards one matrix mult-add result per word instead.
// A global halt freezes the sequencer. BRAM read data and matrix results
// that arrive during a halt are parked in one-entry holding registers, so
// nothing is lost and no read is reissued.

module conv1_feed_sched #(
   parameter int LANES     = 25,
   parameter int DW        = 16,
   parameter int ADDR_W    = 10,
   parameter int NUM_WORDS = 1024,
   parameter int RD_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  halt,
   input  logic                  mode,
   output logic                  bram_rd,
   output logic [ADDR_W-1:0]     bram_addr,
   input  logic [LANES*DW-1:0]   bram_data,
   input  logic [DW-1:0]         mx_res,
   input  logic                  mx_res_v,
   output logic [DW-1:0]         fea_out,
   output logic                  fea_v,
   output logic [4:0]            lane_idx,
   output logic                  busy,
   output logic                  done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_SERIAL = 3'd3;
   localparam logic [2:0] S_MXWAIT = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
   localparam logic [4:0]        LAST_LANE = 5'(LANES - 1);

   logic [2:0]            state_q,    state_d;
   logic [ADDR_W-1:0]     word_q,     word_d;
   logic [4:0]            lane_q,     lane_d;
   logic                  mode_q,     mode_d;
   logic [LANES*DW-1:0]   word_reg_q, word_reg_d;
   logic [RD_LAT-1:0]     rd_pipe_q,  rd_pipe_d;
   logic                  ret_v_q,    ret_v_d;
   logic [LANES*DW-1:0]   ret_data_q, ret_data_d;
   logic                  skid_v_q,   skid_v_d;
   logic [DW-1:0]         skid_data_q, skid_data_d;
   logic                  err_q,      err_d;

   logic                  rd_ret;
   logic                  last_word;
   logic                  skid_pop;
   logic                  pass_active;
   logic [2:0]            after_word;
   logic [2:0]            after_fetch;

   // Output decode: strobes are gated by halt so a stalled cycle never emits anything
   always_comb begin
      bram_rd   = (state_q == S_FETCH) && !halt;
      bram_addr = word_q;
      fea_v     = !halt && ((state_q == S_SERIAL) ||
                            ((state_q == S_MXWAIT) && skid_v_q));
      fea_out   = '0;
      if (fea_v) begin
         if (state_q == S_SERIAL) begin
            fea_out = word_reg_q[int'(lane_q) * DW +: DW];
         end else begin
            fea_out = skid_data_q;
         end
      end
      lane_idx  = lane_q;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE) && !halt;
   end

   // Helper terms shared by the holding registers and the sequencer
   always_comb begin
      rd_ret      = rd_pipe_q[RD_LAT-1];
      last_word   = (word_q == LAST_WORD);
      skid_pop    = (state_q == S_MXWAIT) && !halt && skid_v_q;
      pass_active = (state_q != S_IDLE) && (state_q != S_DONE);
      after_word  = last_word ? S_DONE : S_FETCH;
      after_fetch = mode_q ? S_MXWAIT : S_SERIAL;
   end

   // Next-state logic: read tracking and holding registers run regardless of
   // halt, while the sequencer itself only advances when halt is low
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      lane_d      = lane_q;
      mode_d      = mode_q;
      word_reg_d  = word_reg_q;
      ret_v_d     = ret_v_q;
      ret_data_d  = ret_data_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      err_d       = err_q;

      // The BRAM keeps its own latency even while we are stalled, so the
      // outstanding-read tracker is never frozen.
      rd_pipe_d = (rd_pipe_q << 1) | RD_LAT'(bram_rd);

      // Read data returning while halted is parked until WAIT can take it.
      if (rd_ret && halt) begin
         ret_v_d    = 1'b1;
         ret_data_d = bram_data;
      end

      // Matrix results may land at any time during a pass, halted or not.
      // A result that finds the buffer still occupied is dropped and flagged.
      if (mx_res_v && pass_active) begin
         if (skid_v_q && !skid_pop) begin
            err_d = 1'b1;
         end else begin
            skid_v_d    = 1'b1;
            skid_data_d = mx_res;
         end
      end else if (skid_pop) begin
         skid_v_d = 1'b0;
      end

      if (!halt) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_FETCH;
                  mode_d  = mode;
                  word_d  = '0;
                  lane_d  = '0;
               end
            end
            S_FETCH: begin
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (ret_v_q) begin
                  word_reg_d = ret_data_q;
                  ret_v_d    = 1'b0;
                  state_d    = after_fetch;
               end else if (rd_ret) begin
                  word_reg_d = bram_data;
                  state_d    = after_fetch;
               end
            end
            S_SERIAL: begin
               if (lane_q == LAST_LANE) begin
                  lane_d  = '0;
                  state_d = after_word;
                  if (!last_word) begin
                     word_d = word_q + ADDR_W'(1);
                  end
               end else begin
                  lane_d = lane_q + 5'd1;
               end
            end
            S_MXWAIT: begin
               if (skid_v_q) begin
                  state_d = after_word;
                  if (!last_word) begin
                     word_d = word_q + ADDR_W'(1);
                  end
               end
            end
            S_DONE: begin
               // Leftover matrix results must not leak into the next pass.
               state_d  = S_IDLE;
               word_d   = '0;
               skid_v_d = 1'b0;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         word_q      <= '0;
         lane_q      <= '0;
         mode_q      <= 1'b0;
         word_reg_q  <= '0;
         rd_pipe_q   <= '0;
         ret_v_q     <= 1'b0;
         ret_data_q  <= '0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         lane_q      <= lane_d;
         mode_q      <= mode_d;
         word_reg_q  <= word_reg_d;
         rd_pipe_q   <= rd_pipe_d;
         ret_v_q     <= ret_v_d;
         ret_data_q  <= ret_data_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_conv1_feed_sched.sv
// tb_conv1_feed_sched
// Scoreboard bench for conv1_feed_sched (3-word passes, RD_LAT=2). Stimulus
// tasks push the samples and done events they expect; a negedge monitor pops
// and compares whenever the DUT raises fea_v or done.

module tb_conv1_feed_sched;

   localparam int LANES  = 25;
   localparam int DW     = 16;
   localparam int ADDR_W = 10;
   localparam int NW     = 3;
   localparam int RDL    = 2;

   typedef struct packed {
      logic        isDone;
      logic [15:0] data;
      logic [4:0]  lane;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 halt = 1'b0;
   logic                 mode = 1'b0;
   logic                 bramRd;
   logic [ADDR_W-1:0]    bramAddr;
   logic [LANES*DW-1:0]  bramData;
   logic [DW-1:0]        mxRes = '0;
   logic                 mxResV = 1'b0;
   logic [DW-1:0]        feaOut;
   logic                 feaV;
   logic [4:0]           laneIdx;
   logic                 busy;
   logic                 done;

   exp_t expQ[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   rdCnt = 0;
   int   doneCnt = 0;
   int   doneCyc = 0;
   int   firstFv = -1;
   int   lastFv = 0;
   int   startCyc = 0;

   logic [ADDR_W-1:0] a1 = '0, a2 = '0;
   logic              v1 = 1'b0, v2 = 1'b0;

   conv1_feed_sched #(
      .LANES(LANES), .DW(DW), .ADDR_W(ADDR_W), .NUM_WORDS(NW), .RD_LAT(RDL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .mode(mode),
      .bram_rd(bramRd), .bram_addr(bramAddr), .bram_data(bramData),
      .mx_res(mxRes), .mx_res_v(mxResV),
      .fea_out(feaOut), .fea_v(feaV), .lane_idx(laneIdx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Cycle counter and BRAM read counter
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bramRd === 1'b1) rdCnt <= rdCnt + 1;
   end

   function automatic logic [15:0] laneVal(input int a, input int k);
      return {8'(a), 8'(k + 1)};
   endfunction

   // BRAM model: two-stage read pipe; data is garbage outside the valid cycle
   always @(posedge clk) begin
      v1 <= (bramRd === 1'b1);
      if (bramRd === 1'b1) a1 <= bramAddr;
      v2 <= v1;
      a2 <= a1;
   end

   always_comb begin
      bramData = '0;
      for (int k = 0; k < LANES; k++) begin
         bramData[16*k +: 16] = v2 ? laneVal(int'(a2), k) : 16'hBAD0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   // Monitor: every fea_v or done pops one expected event
   always @(negedge clk) begin
      exp_t e;
      if (feaV === 1'b1 || done === 1'b1) begin
         if (feaV === 1'b1) begin
            if (firstFv < 0) firstFv = cyc;
            lastFv = cyc;
         end
         if (done === 1'b1) begin
            doneCnt++;
            doneCyc = cyc;
         end
         if (expQ.size() == 0) begin
            checkOutput("sb_underflow", 32'(expQ.size()), 32'd1);
         end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", {30'b0, done, feaV}, e.isDone ? 32'd2 : 32'd1);
            if (!e.isDone) begin
               checkOutput("fea_out", {16'b0, feaOut}, {16'b0, e.data});
               checkOutput("lane_idx", {27'b0, laneIdx}, {27'b0, e.lane});
            end
         end
      end
   end

   task automatic pushSample(input logic [15:0] d, input int lane);
      exp_t e;
      e.isDone = 1'b0;
      e.data   = d;
      e.lane   = 5'(lane);
      expQ.push_back(e);
   endtask

   task automatic pushDone();
      exp_t e;
      e.isDone = 1'b1;
      e.data   = '0;
      e.lane   = '0;
      expQ.push_back(e);
   endtask

   task automatic pushBypass(input int nWords);
      for (int w = 0; w < nWords; w++)
         for (int k = 0; k < LANES; k++)
            pushSample(laneVal(w, k), k);
   endtask

   // Issue a one-cycle start pulse with the given mode
   task automatic applyStimulus(input logic m);
      @(posedge clk); #1;
      start = 1'b1;
      mode  = m;
      startCyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input string name, input int budget);
      int  d0;
      bit  got;
      d0  = doneCnt;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(posedge clk);
         if (doneCnt > d0) got = 1'b1;
      end
      checkOutput(name, {31'b0, got}, 32'd1);
   endtask

   task automatic waitBramRd(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (bramRd === 1'b1) got = 1'b1;
      end
      checkOutput(name, {31'b0, got}, 32'd1);
   endtask

   task automatic waitLane(input string name, input logic [4:0] l);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (feaV === 1'b1 && laneIdx == l) got = 1'b1;
      end
      checkOutput(name, {31'b0, got}, 32'd1);
   endtask

   task automatic feedMx(input string name, input int w, input logic [15:0] val);
      waitBramRd({name, "_rd"});
      checkOutput({name, "_addr"}, 32'(bramAddr), 32'(w));
      repeat (3) @(posedge clk);
      #1;
      mxResV = 1'b1;
      mxRes  = val;
      @(posedge clk); #1;
      mxResV = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rd0, hv, lb, d0;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_fea_v", {31'b0, feaV}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_bram_rd", {31'b0, bramRd}, 32'd0);
      checkOutput("rst_addr", 32'(bramAddr), 32'd0);
      checkOutput("rst_lane", 32'(laneIdx), 32'd0);
      checkOutput("rst_fea_out", 32'(feaOut), 32'd0);
      checkOutput("rst_err", {31'b0, dut.err_q}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // T1: plain bypass pass; mode input toggled mid-pass must not matter
      pushBypass(NW);
      pushDone();
      rd0 = rdCnt;
      firstFv = -1;
      applyStimulus(1'b0);
      mode = 1'b1;
      @(negedge clk);
      checkOutput("t1_busy", {31'b0, busy}, 32'd1);
      checkOutput("t1_fetch_rd", {31'b0, bramRd}, 32'd1);
      waitDone("t1_done_seen", 400);
      checkOutput("t1_first_latency", 32'(firstFv - startCyc), 32'(RDL + 2));
      checkOutput("t1_done_after_last", 32'(doneCyc - lastFv), 32'd1);
      @(negedge clk);
      checkOutput("t1_busy_low", {31'b0, busy}, 32'd0);
      checkOutput("t1_rd_count", 32'(rdCnt - rd0), 32'(NW));
      mode = 1'b0;

      // T2: halt for 5 cycles while lane 7 is due
      pushBypass(NW);
      pushDone();
      applyStimulus(1'b0);
      waitLane("t2_lane6", 5'd6);
      @(posedge clk); #1;
      halt = 1'b1;
      hv = 0;
      lb = 0;
      repeat (5) begin
         @(negedge clk);
         if (feaV !== 1'b0) hv++;
         if (laneIdx != 5'd7) lb++;
      end
      checkOutput("t2_fv_in_halt", 32'(hv), 32'd0);
      checkOutput("t2_lane_hold", 32'(lb), 32'd0);
      @(posedge clk); #1;
      halt = 1'b0;
      @(negedge clk);
      checkOutput("t2_resume_lane", 32'(laneIdx), 32'd7);
      waitDone("t2_done_seen", 400);

      // T3: halt the cycle after bram_rd; data returns during the halt
      pushBypass(NW);
      pushDone();
      rd0 = rdCnt;
      applyStimulus(1'b0);
      waitBramRd("t3_rd");
      @(posedge clk); #1;
      halt = 1'b1;
      hv = 0;
      lb = 0;
      repeat (6) begin
         @(negedge clk);
         if (bramRd !== 1'b0) lb++;
         if (feaV !== 1'b0) hv++;
      end
      checkOutput("t3_rd_in_halt", 32'(lb), 32'd0);
      checkOutput("t3_fv_in_halt", 32'(hv), 32'd0);
      @(posedge clk); #1;
      halt = 1'b0;
      waitDone("t3_done_seen", 400);
      checkOutput("t3_rd_count", 32'(rdCnt - rd0), 32'(NW));

      // T4: matrix mode forwards one result per word
      pushSample(16'h1111, 0);
      pushSample(16'h2222, 0);
      pushSample(16'h3333, 0);
      pushDone();
      rd0 = rdCnt;
      applyStimulus(1'b1);
      feedMx("t4_w0", 0, 16'h1111);
      feedMx("t4_w1", 1, 16'h2222);
      feedMx("t4_w2", 2, 16'h3333);
      waitDone("t4_done_seen", 100);
      checkOutput("t4_rd_count", 32'(rdCnt - rd0), 32'(NW));

      // T5: two results while halted -> first kept, overflow flagged
      checkOutput("t5_err_before", {31'b0, dut.err_q}, 32'd0);
      pushSample(16'hAAAA, 0);
      pushSample(16'h4444, 0);
      pushSample(16'h5555, 0);
      pushDone();
      applyStimulus(1'b1);
      waitBramRd("t5_rd");
      repeat (3) @(posedge clk);
      #1;
      halt   = 1'b1;
      mxResV = 1'b1;
      mxRes  = 16'hAAAA;
      @(posedge clk); #1;
      mxRes  = 16'hBBBB;
      @(posedge clk); #1;
      mxResV = 1'b0;
      hv = 0;
      repeat (2) begin
         @(negedge clk);
         if (feaV !== 1'b0) hv++;
      end
      checkOutput("t5_fv_in_halt", 32'(hv), 32'd0);
      checkOutput("t5_err_set", {31'b0, dut.err_q}, 32'd1);
      @(posedge clk); #1;
      halt = 1'b0;
      feedMx("t5_w1", 1, 16'h4444);
      feedMx("t5_w2", 2, 16'h5555);
      waitDone("t5_done_seen", 100);

      // T6a: start together with halt in IDLE is ignored
      rd0 = rdCnt;
      @(posedge clk); #1;
      start = 1'b1;
      halt  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      halt  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t6_start_halt_busy", {31'b0, busy}, 32'd0);
      checkOutput("t6_start_halt_rd", 32'(rdCnt - rd0), 32'd0);

      // T6b: start while busy ignored, then reset mid-pass aborts silently
      pushBypass(1);
      applyStimulus(1'b0);
      waitLane("t6_lane3", 5'd3);
      @(posedge clk); #1;
      start = 1'b1;
      mode  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = 1'b0;
      waitLane("t6_lane24", 5'd24);
      d0 = doneCnt;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6_rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("t6_rst_fea_v", {31'b0, feaV}, 32'd0);
      checkOutput("t6_rst_bram_rd", {31'b0, bramRd}, 32'd0);
      checkOutput("t6_rst_addr", 32'(bramAddr), 32'd0);
      checkOutput("t6_rst_lane", 32'(laneIdx), 32'd0);
      checkOutput("t6_rst_fea_out", 32'(feaOut), 32'd0);
      checkOutput("t6_rst_err", {31'b0, dut.err_q}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("t6_no_done", 32'(doneCnt - d0), 32'd0);
      checkOutput("t6_idle_busy", {31'b0, busy}, 32'd0);

      checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
